spi_serf: RTL and testbench
===========================

# spi_serf

SPI serf (subordinate) for the 16-bit SPI link driven by the team's SPI monarch, SPI mode 3 (SCLK idles high; data sampled on SCLK rise, next bit presented after the rise). It oversamples SS_n/SCLK/MOSI on the system clock, shifts one full-duplex 16-bit frame per SS_n-low window, and returns a preloaded response word on MISO. Received words are handed to the core with a sticky ready flag; aborted or over-length frames are flagged as errors. Used wherever a block must answer the monarch, such as inertial sensor or peripheral emulators and test benches.

## Interface
- Parameters: none (frame width fixed at 16 bits).
- clk  in  1  system clock; must run at least 8x SCLK.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  serf select from monarch, active low, asynchronous to clk.
- SCLK  in  1  serial clock from monarch, asynchronous, idles high.
- MOSI  in  1  serial data from monarch, MSB first.
- MISO  out  1  serial data to monarch, MSB first.
- tx_data  in  16  response word for the next frame.
- wrt  in  1  1-clk pulse: load tx_data into tx_buf.
- clr_rdy  in  1  1-clk pulse: clear rdy.
- rx_data  out  16  last correctly received word.
- rdy  out  1  sticky: rx_data holds a new word.
- err  out  1  1-clk pulse: frame ended with bit count != 16.

## Operation
- Synchronizers: SS_n, SCLK, MOSI each pass through 3 flops (ff1..ff3). SS_n and SCLK flops reset to 1, MOSI flops to 0.
- Edge detects:
  - sclk_rise = SCLK_ff2 & ~SCLK_ff3.
  - ss_fall = ~SS_n_ff2 & SS_n_ff3.
  - ss_rise = SS_n_ff2 & ~SS_n_ff3.
- tx_buf (16b, reset 0): loaded from tx_data on wrt, in any state. A wrt during a frame affects only the next frame.
- State machine, states IDLE and SHIFT, reset IDLE:
  - IDLE: on ss_fall, load shft <= tx_buf, bit_cnt <= 0, go to SHIFT. If wrt coincides with ss_fall, tx_data bypasses to shft directly.
  - SHIFT: on sclk_rise, shft <= {shft[14:0], MOSI_ff3}. MOSI_ff3 is the pre-rise value. bit_cnt increments, saturating at 17.
  - SHIFT, on ss_rise: if bit_cnt == 16, rx_data <= shft and rdy <= 1. Otherwise pulse err for 1 clk and leave rx_data and rdy unchanged. Go to IDLE in both cases.
  - ss_rise takes priority over a coincident sclk_rise; that SCLK edge is ignored.
- MISO = shft[15] while SS_n_ff2 == 0, else 0.
- rdy: set on a good frame end, cleared by clr_rdy or by ss_fall. Set wins over a simultaneous clr_rdy.
- Reset mid-frame: all state returns to its reset value immediately. If SS_n is still low at reset release, it is treated as an ss_fall 2 clks later. That partial frame then ends with err.

## Timing
- Reset values: MISO 0, rx_data 16'h0000, rdy 0, err 0, state IDLE, bit_cnt 0, shft 0.
- Shift latency: the shift register updates on the 3rd clk rising edge after the SCLK rise, counting the sampling edge. MISO therefore changes 3 clks after each SCLK rise. The monarch has already sampled by then, and the next rise is ≥8 clks away.
- Frame start: shft is loaded 3 clks after SS_n falls. MISO presents tx_buf[15] ≥5 clks before the first SCLK rise, given the monarch's 8-clk half period.
- Frame end: rx_data, rdy, or the err pulse appear 3 clks after SS_n rises.
- Back-to-back frames require SS_n high for ≥3 clks.

## Test plan
- wrt with tx_data=16'hA5C3; monarch sends 16'h1234 -> rx_data=16'h1234, rdy=1, err=0, monarch receives 16'hA5C3.
- Two frames with no wrt between them (1st MOSI 16'h0001, 2nd 16'hFFFF), clr_rdy pulsed between -> the 2nd frame also returns 16'hA5C3, rdy drops on clr_rdy then re-sets, rx_data=16'hFFFF.
- SS_n raised after 7 SCLK rises -> err high exactly 1 clk, rdy stays 0, rx_data keeps its previous value.
- wrt with 16'hFFFF at bit 5 of a frame -> the current frame still returns the old word, the next frame returns 16'hFFFF. wrt coincident with ss_fall -> the new word is sent in that frame.
- clr_rdy in the same clk as a good frame end -> rdy=1. 18 SCLK rises in one frame -> err pulse, rdy unchanged.
- rst_n asserted at bit 9 -> all outputs at reset values within the reset cycle; a following full frame with 16'hBEEF gives rx_data=16'hBEEF, rdy=1.

Source files
------------

// File: rtl/spi_serf.sv
// SPI mode-3 subordinate: oversamples SS_n/SCLK/MOSI on clk, shifts one
// full-duplex 16-bit frame per SS_n-low window and flags short/long frames.
module spi_serf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  input  logic        wrt,
  input  logic        clr_rdy,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        err
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CNT_MAX = FRAME_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_ss_ff1, r_ss_ff2, r_ss_ff3;
  logic               r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
  logic               r_mosi_ff1, r_mosi_ff2, r_mosi_ff3;

  logic [FRAME_W-1:0] r_tx_buf, w_tx_buf_nxt;
  logic [FRAME_W-1:0] r_shft, w_shft_nxt;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_W-1:0] r_rx_data, w_rx_data_nxt;
  logic               r_rdy, w_rdy_nxt;
  logic               r_err, w_err_nxt;
  logic               r_miso, w_miso_nxt;

  logic               w_sclk_rise;
  logic               w_ss_fall;
  logic               w_ss_rise;

  // Three-flop synchronizers; ff3 only feeds edge detection and the shift input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_ff1   <= 1'b1;
      r_ss_ff2   <= 1'b1;
      r_ss_ff3   <= 1'b1;
      r_sclk_ff1 <= 1'b1;
      r_sclk_ff2 <= 1'b1;
      r_sclk_ff3 <= 1'b1;
      r_mosi_ff1 <= 1'b0;
      r_mosi_ff2 <= 1'b0;
      r_mosi_ff3 <= 1'b0;
    end else begin
      r_ss_ff1   <= SS_n;
      r_ss_ff2   <= r_ss_ff1;
      r_ss_ff3   <= r_ss_ff2;
      r_sclk_ff1 <= SCLK;
      r_sclk_ff2 <= r_sclk_ff1;
      r_sclk_ff3 <= r_sclk_ff2;
      r_mosi_ff1 <= MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
      r_mosi_ff3 <= r_mosi_ff2;
    end
  end

  assign w_sclk_rise = r_sclk_ff2 & ~r_sclk_ff3;
  assign w_ss_fall   = ~r_ss_ff2 & r_ss_ff3;
  assign w_ss_rise   = r_ss_ff2 & ~r_ss_ff3;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx_buf  <= '0;
      r_shft    <= '0;
      r_bit_cnt <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
      r_miso    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_buf  <= w_tx_buf_nxt;
      r_shft    <= w_shft_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_rdy     <= w_rdy_nxt;
      r_err     <= w_err_nxt;
      r_miso    <= w_miso_nxt;
    end
  end

  // Next-state and datapath decode; ss_rise wins over a coincident sclk_rise
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_buf_nxt  = wrt ? tx_data : r_tx_buf;
    w_shft_nxt    = r_shft;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rx_data_nxt = r_rx_data;
    w_rdy_nxt     = r_rdy;
    w_err_nxt     = 1'b0;

    if (clr_rdy || w_ss_fall) begin
      w_rdy_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_shft_nxt    = wrt ? tx_data : r_tx_buf;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          if (r_bit_cnt == CNT_W'(FRAME_W)) begin
            w_rx_data_nxt = r_shft;
            w_rdy_nxt     = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_shft_nxt = {r_shft[FRAME_W-2:0], r_mosi_ff3};
          if (r_bit_cnt != CNT_W'(CNT_MAX)) begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
      end
    endcase

    // Registered copy of shft[15] gated by the synchronized select
    w_miso_nxt = ~r_ss_ff1 & w_shft_nxt[FRAME_W-1];
  end

  assign MISO    = r_miso;
  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign err     = r_err;

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a behavioural mode-3 monarch drives frames from
// a vector table, followed by hand-built sequences for mid-frame events.
module tb_spi_serf;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic        wrt;
  logic        clr_rdy;
  logic [15:0] rx_data;
  logic        rdy;
  logic        err;

  int n_chk;
  int n_pass;
  int err_cnt;

  spi_serf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt     (wrt),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clocks with err high
  always @(negedge clk) if (err === 1'b1) err_cnt++;

  typedef struct {
    logic        do_wrt;
    logic [15:0] wdata;
    logic [15:0] mosi;
    int          nrise;
    logic        chk_miso;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_rdy;
    int          exp_err;
    logic        clr_after;
  } vec_t;

  vec_t vecs[11];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One SS_n-low window. wrt_at=-2: wrt coincident with ss_fall detection;
  // wrt_at>=0: wrt pulse before that SCLK rise; rst_at>=0: reset pulse there.
  task automatic run_frame(input logic [15:0] mosi_w, input int nrise,
                           input int wrt_at, input logic [15:0] wrt_val,
                           input logic clr_end, input int rst_at,
                           output logic [15:0] miso_w, output logic rdy_early);
    logic [15:0] mw;
    mw      = 16'h0000;
    err_cnt = 0;
    SS_n    = 1'b0;
    if (wrt_at == -2) begin
      tick(2);
      tx_data = wrt_val;
      wrt     = 1'b1;
      tick(1);
      wrt     = 1'b0;
      tick(5);
    end else begin
      tick(8);
    end
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? mosi_w[4'(15 - i)] : 1'b0;
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst MISO", 32'(MISO), 32'h0);
        chk("rst rx_data", 32'(rx_data), 32'h0);
        chk("rst rdy", 32'(rdy), 32'h0);
        chk("rst err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(7);
      end else if (i == wrt_at) begin
        tick(1);
        tx_data = wrt_val;
        wrt     = 1'b1;
        tick(1);
        wrt     = 1'b0;
        tick(6);
      end else begin
        tick(8);
      end
      mw   = {mw[14:0], MISO};
      SCLK = 1'b1;
      tick(8);
    end
    SS_n = 1'b1;
    tick(2);
    rdy_early = rdy;
    if (clr_end) begin
      clr_rdy = 1'b1;
      tick(1);
      clr_rdy = 1'b0;
    end else begin
      tick(1);
    end
    tick(4);
    miso_w = mw;
  endtask

  initial begin
    logic [15:0] miso_w;
    logic        rdy_e;
    vec_t        v;

    n_chk   = 0;
    n_pass  = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    tx_data = 16'h0000;
    wrt     = 1'b0;
    clr_rdy = 1'b0;

    //            wrt   wdata     mosi      n   chkm  exp_miso  exp_rx    rdy  err clr
    vecs[0]  = '{1'b1, 16'hA5C3, 16'h1234, 16, 1'b1, 16'hA5C3, 16'h1234, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0001, 16, 1'b1, 16'hA5C3, 16'h0001, 1'b1, 0, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 16'hFFFF, 16, 1'b1, 16'hA5C3, 16'hFFFF, 1'b1, 0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 16'h5555,  7, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0F0F, 16'h8001, 18, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0F0F, 16, 1'b1, 16'h0F0F, 16'h0F0F, 1'b1, 0, 1'b0};
    vecs[6]  = '{1'b1, 16'h8421, 16'hFFFF, 16, 1'b1, 16'h8421, 16'hFFFF, 1'b1, 0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h1111, 15, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h2222, 17, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 16'h3333,  0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 16'hC3A5, 16, 1'b1, 16'h8421, 16'hC3A5, 1'b1, 0, 1'b0};

    tick(3);
    chk("reset MISO", 32'(MISO), 32'h0);
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rdy", 32'(rdy), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      if (v.do_wrt) begin
        tx_data = v.wdata;
        wrt     = 1'b1;
        tick(1);
        wrt     = 1'b0;
        tick(1);
      end
      run_frame(v.mosi, v.nrise, -1, 16'h0000, 1'b0, -1, miso_w, rdy_e);
      if (v.chk_miso) chk($sformatf("v%0d miso", i), 32'(miso_w), 32'(v.exp_miso));
      chk($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(v.exp_rx));
      chk($sformatf("v%0d rdy", i), 32'(rdy), 32'(v.exp_rdy));
      chk($sformatf("v%0d err_cycles", i), 32'(err_cnt), 32'(v.exp_err));
      chk($sformatf("v%0d rdy_latency", i), 32'(rdy_e), 32'h0);
      if (v.clr_after) begin
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        chk($sformatf("v%0d clr_rdy", i), 32'(rdy), 32'h0);
      end
    end

    // wrt mid-frame only affects the following frame
    run_frame(16'h1357, 16, 5, 16'hFFFF, 1'b0, -1, miso_w, rdy_e);
    chk("midwrt cur miso", 32'(miso_w), 32'h8421);
    chk("midwrt cur rx", 32'(rx_data), 32'h1357);
    chk("midwrt cur rdy", 32'(rdy), 32'h1);
    run_frame(16'h2468, 16, -1, 16'h0000, 1'b0, -1, miso_w, rdy_e);
    chk("midwrt next miso", 32'(miso_w), 32'hFFFF);
    chk("midwrt next rx", 32'(rx_data), 32'h2468);

    // wrt coincident with ss_fall bypasses into the current frame
    run_frame(16'h0042, 16, -2, 16'h6A6A, 1'b0, -1, miso_w, rdy_e);
    chk("bypass miso", 32'(miso_w), 32'h6A6A);
    chk("bypass rx", 32'(rx_data), 32'h0042);

    // clr_rdy on the frame-end clock loses to the set
    run_frame(16'h9ABC, 16, -1, 16'h0000, 1'b1, -1, miso_w, rdy_e);
    chk("clr_at_end miso", 32'(miso_w), 32'h6A6A);
    chk("clr_at_end rx", 32'(rx_data), 32'h9ABC);
    chk("clr_at_end rdy", 32'(rdy), 32'h1);
    chk("clr_at_end early rdy", 32'(rdy_e), 32'h0);

    // Reset at bit 9 with SS_n held low: remaining partial frame ends in err
    run_frame(16'hDEAD, 16, -1, 16'h0000, 1'b0, 9, miso_w, rdy_e);
    chk("postrst err_cycles", 32'(err_cnt), 32'h1);
    chk("postrst rdy", 32'(rdy), 32'h0);
    chk("postrst rx", 32'(rx_data), 32'h0);
    run_frame(16'hBEEF, 16, -1, 16'h0000, 1'b0, -1, miso_w, rdy_e);
    chk("beef rx", 32'(rx_data), 32'hBEEF);
    chk("beef rdy", 32'(rdy), 32'h1);
    chk("beef err_cycles", 32'(err_cnt), 32'h0);
    chk("beef miso", 32'(miso_w), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
